// File: rtl/shift_out32_pkg.sv
// Shared types and sizes for the shift_out32 serializer.
// SHIFT_OUT32_PARITY_EN selects a 33-bit frame with a trailing even-parity bit.
package shift_out32_pkg;

    localparam int unsigned DATA_BITS = 32;
`ifdef SHIFT_OUT32_PARITY_EN
    localparam int unsigned FRAME_BITS = DATA_BITS + 1;
`else
    localparam int unsigned FRAME_BITS = DATA_BITS;
`endif
    localparam int unsigned BITCNT_W = 5;
    localparam int unsigned DIVCNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_out32_bit_tick.sv
// Bit-period divider: tick_c pulses once every DIV enabled cycles.
// clr_i restarts the period so the first tick lands DIV cycles after a load.
module bit_tick
    import shift_out32_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_c
);

    logic [DIVCNT_W-1:0] cnt_q, cnt_d;

    assign tick_c = en_i && (cnt_q == DIVCNT_W'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || tick_c) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + DIVCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shift_out32.sv
// 32-bit parallel-to-serial converter, LSB first, DIV clocks per bit.
// Define SHIFT_OUT32_PARITY_EN to append an even-parity bit to each frame.
module shift_out32
    import shift_out32_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic                 clk,
    input  logic                 R,
    input  logic [DATA_BITS-1:0] in,
    input  logic                 load_valid,
    output logic                 load_ready,
    output logic                 sout,
    output logic                 sout_valid,
    output logic                 sof,
    output logic                 done
);

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic                  load_ready_q, load_ready_d;
    logic                  sout_q, sout_d;
    logic                  sout_valid_q, sout_valid_d;
    logic                  sof_q, sof_d;
    logic                  done_q, done_d;
    logic                  transfer_c;
    logic                  tick_c;
    logic                  last_bit_c;

`ifdef SHIFT_OUT32_PARITY_EN
    // Parity bit follows data bit 31; the 5-bit counter parks at 31 meanwhile.
    logic par_q, par_d;
    assign last_bit_c = par_q;
`else
    assign last_bit_c = (bitcnt_q == BITCNT_W'(DATA_BITS - 1));
`endif

    assign transfer_c = (state_q == IDLE) && load_valid && load_ready_q;

    bit_tick #(.DIV(DIV)) u_bit_tick (
        .clk    (clk),
        .rst_n  (R),
        .clr_i  (transfer_c),
        .en_i   (state_q == SHIFT),
        .tick_c (tick_c)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
`ifdef SHIFT_OUT32_PARITY_EN
        par_d    = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (transfer_c) begin
`ifdef SHIFT_OUT32_PARITY_EN
                    shreg_d = {^in, in};
                    par_d   = 1'b0;
`else
                    shreg_d = FRAME_BITS'(in);
`endif
                    bitcnt_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (tick_c) begin
                    if (last_bit_c) begin
                        state_d = DONE;
                    end else begin
                        shreg_d = shreg_q >> 1;
                        if (bitcnt_q != BITCNT_W'(DATA_BITS - 1)) begin
                            bitcnt_d = bitcnt_q + BITCNT_W'(1);
                        end
`ifdef SHIFT_OUT32_PARITY_EN
                        else begin
                            par_d = 1'b1;
                        end
`endif
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from next-state so they align with the state they describe.
        load_ready_d = (state_d == IDLE);
        sout_valid_d = (state_d == SHIFT);
        sout_d       = (state_d == SHIFT) && shreg_d[0];
        sof_d        = (state_d == SHIFT) && (bitcnt_d == '0);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            load_ready_q <= 1'b0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            load_ready_q <= load_ready_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            sof_q        <= sof_d;
            done_q       <= done_d;
        end
    end

`ifdef SHIFT_OUT32_PARITY_EN
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    assign load_ready = load_ready_q;
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign sof        = sof_q;
    assign done       = done_q;

endmodule

// File: tb/tb_shift_out32.sv
// Directed bench for shift_out32: one DUT with DIV=1 and one with DIV=4.
// Honours SHIFT_OUT32_PARITY_EN for the expected frame length.
module tb_shift_out32;

`ifdef SHIFT_OUT32_PARITY_EN
    localparam int NB = 33;
`else
    localparam int NB = 32;
`endif

    logic        clk;
    logic        R;
    logic [31:0] din [2];
    logic        lv  [2];
    logic        ready [2];
    logic        so  [2];
    logic        sv  [2];
    logic        sf  [2];
    logic        dn  [2];

    int n_checks;
    int n_pass;

    shift_out32 #(.DIV(1)) u_div1 (
        .clk(clk), .R(R), .in(din[0]), .load_valid(lv[0]), .load_ready(ready[0]),
        .sout(so[0]), .sout_valid(sv[0]), .sof(sf[0]), .done(dn[0])
    );

    shift_out32 #(.DIV(4)) u_div4 (
        .clk(clk), .R(R), .in(din[1]), .load_valid(lv[1]), .load_ready(ready[1]),
        .sout(so[1]), .sout_valid(sv[1]), .sof(sf[1]), .done(dn[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge with the DUT idle; returns the serialized data word and final bit.
    task automatic run_frame(input int d, input logic [31:0] w, input bit busy,
                             output logic [31:0] got, output logic last);
        int   div;
        logic exp_bit;
        div = (d != 0) ? 4 : 1;
        got = '0;
        last = 1'b0;
        check($sformatf("ready_pre%0d", d), 32'(ready[d]), 32'd1);
        din[d] = w;
        lv[d]  = 1'b1;
        @(negedge clk);
        if (!busy) lv[d] = 1'b0;
        for (int k = 0; k < NB; k++) begin
            exp_bit = (k < 32) ? w[k] : ^w;
            for (int c = 0; c < div; c++) begin
                check($sformatf("sout%0d[%0d.%0d]", d, k, c), 32'(so[d]), 32'(exp_bit));
                check($sformatf("valid%0d[%0d]", d, k), 32'(sv[d]), 32'd1);
                check($sformatf("sof%0d[%0d]", d, k), 32'(sf[d]), 32'(k == 0));
                check($sformatf("busy_ready%0d[%0d]", d, k), {31'd0, ready[d]} | {31'd0, dn[d]}, 32'd0);
                if (c == 0 && k < 32) got[k] = so[d];
                if (k == NB - 1) last = so[d];
                if (busy) din[d] = $urandom;
                @(negedge clk);
            end
        end
        check($sformatf("done%0d", d), {29'd0, dn[d], sv[d], ready[d]}, 32'b100);
        @(negedge clk);
        check($sformatf("post%0d", d), {30'd0, dn[d], ready[d]}, 32'b01);
    endtask

    initial begin
        logic [31:0] got;
        logic        last;
        n_checks = 0;
        n_pass   = 0;
        R = 1'b0;
        for (int i = 0; i < 2; i++) begin
            din[i] = 32'hFFFF_FFFF;
            lv[i]  = 1'b1;
        end

        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                check($sformatf("rst_outs%0d", i),
                      {27'd0, ready[i], so[i], sv[i], sf[i], dn[i]}, 32'd0);
        end
        R = 1'b1;
        check("ready_at_release", 32'(ready[0]), 32'd0);
        @(negedge clk);
        check("ready_after_edge0", 32'(ready[0]), 32'd1);
        check("ready_after_edge1", 32'(ready[1]), 32'd1);
        check("no_frame_after_rst", 32'(sv[0]), 32'd0);
        lv[0] = 1'b0;
        lv[1] = 1'b0;

        run_frame(0, 32'hA5A5_0F01, 1'b0, got, last);
        check("basic_word", got, 32'hA5A5_0F01);

        run_frame(1, 32'h8000_0001, 1'b0, got, last);
        check("div4_word", got, 32'h8000_0001);

        run_frame(0, 32'h1234_5678, 1'b1, got, last);
        check("busy_word_a", got, 32'h1234_5678);
        run_frame(0, 32'hCAFE_F00D, 1'b0, got, last);
        check("busy_word_b", got, 32'hCAFE_F00D);

        run_frame(0, 32'h0000_0007, 1'b0, got, last);
        check("par_word", got, 32'h0000_0007);
`ifdef SHIFT_OUT32_PARITY_EN
        check("par_bit", 32'(last), 32'd1);
`else
        check("last_bit", 32'(last), 32'd0);
`endif

        // Abort a frame while bit 10 is on the line.
        din[0] = 32'hFFFF_FFFF;
        lv[0]  = 1'b1;
        @(negedge clk);
        lv[0]  = 1'b0;
        repeat (10) @(negedge clk);
        check("bit10_sout", 32'(so[0]), 32'd1);
        check("bit10_valid", 32'(sv[0]), 32'd1);
        R = 1'b0;
        #1;
        check("abort_sout", 32'(so[0]), 32'd0);
        check("abort_valid", 32'(sv[0]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("abort_done%0d", i), 32'(dn[0]), 32'd0);
        end
        R = 1'b1;
        @(negedge clk);
        check("abort_post_done", 32'(dn[0]), 32'd0);
        run_frame(0, 32'h0F0F_3C3C, 1'b0, got, last);
        check("post_abort_word", got, 32'h0F0F_3C3C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
